// File: rtl/escalonador_regras.sv
// escalonador_regras: per-sample sequencer for the type-2 fuzzy datapath.
// Optional defuzzification timeout is compiled in when DEFUZZY_TIMEOUT_EN is defined.
module escalonador_regras #(
    parameter int unsigned NUM_REGRAS     = 16,
    parameter int unsigned TIMEOUT_CICLOS = 64
) (
    input  logic       clk_0,
    input  logic       Srst,
    input  logic       entrada_valid,
    output logic       entrada_ready,
    input  logic [7:0] Entrada_01,
    input  logic [7:0] Entrada_02,
    output logic [7:0] entrada_01_lat,
    output logic [7:0] entrada_02_lat,
    input  logic       EN_REGRAS,
    output logic [3:0] regra_idx,
    output logic       regra_en,
    output logic       reset_memoria,
    output logic       defuzzy_start,
    input  logic       defuzzy_done,
    input  logic [7:0] saida_defuzzy_in,
    output logic [7:0] saida,
    output logic       saida_valid,
    input  logic       saida_ready,
    output logic       ocupado,
    output logic       erro_timeout
);

    typedef enum logic [2:0] {
        OCIOSO,
        LIMPA,
        REGRAS,
        DISPARO,
        ESPERA,
        SAIDA
    } estado_t;

    localparam logic [3:0] ULTIMA_REGRA = 4'(NUM_REGRAS - 1);

    if (NUM_REGRAS < 1 || NUM_REGRAS > 16 || TIMEOUT_CICLOS < 1 || TIMEOUT_CICLOS > 255) begin : g_param_invalido
        $error("escalonador_regras: NUM_REGRAS or TIMEOUT_CICLOS out of range");
    end

    estado_t estado;
    estado_t proximo;
    logic    estourou;

    function automatic logic [7:0] satura(input logic [7:0] x);
        if (x == 8'h00) return 8'h01;
        if (x == 8'hFF) return 8'hFE;
        return x;
    endfunction

    always_ff @(posedge clk_0 or posedge Srst) begin
        if (Srst) estado <= OCIOSO;
        else      estado <= proximo;
    end

    always_comb begin
        proximo = estado;
        case (estado)
            OCIOSO:  if (entrada_valid) proximo = LIMPA;
            LIMPA:   proximo = REGRAS;
            REGRAS:  if (EN_REGRAS && regra_idx == ULTIMA_REGRA) proximo = DISPARO;
            DISPARO: proximo = ESPERA;
            ESPERA:  if (defuzzy_done || estourou) proximo = SAIDA;
            SAIDA:   if (saida_ready) proximo = OCIOSO;
            default: proximo = OCIOSO;
        endcase
    end

    // Srst drives entrada_ready low and reset_memoria high combinationally while asserted.
    always_comb begin
        entrada_ready = 1'b0;
        reset_memoria = Srst;
        regra_en      = 1'b0;
        defuzzy_start = 1'b0;
        saida_valid   = 1'b0;
        ocupado       = 1'b1;
        case (estado)
            OCIOSO: begin
                entrada_ready = ~Srst;
                ocupado       = 1'b0;
            end
            LIMPA:   reset_memoria = 1'b1;
            REGRAS:  regra_en      = EN_REGRAS;
            DISPARO: defuzzy_start = 1'b1;
            SAIDA:   saida_valid   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_0 or posedge Srst) begin
        if (Srst) begin
            entrada_01_lat <= '0;
            entrada_02_lat <= '0;
            regra_idx      <= '0;
            saida          <= '0;
        end else begin
            if (estado == OCIOSO && entrada_valid) begin
                entrada_01_lat <= satura(Entrada_01);
                entrada_02_lat <= satura(Entrada_02);
            end
            // The last index is held rather than wrapped so it stays visible after REGRAS.
            if (estado == LIMPA)
                regra_idx <= '0;
            else if (estado == REGRAS && EN_REGRAS && regra_idx != ULTIMA_REGRA)
                regra_idx <= regra_idx + 4'd1;
            if (estado == ESPERA) begin
                if (defuzzy_done)  saida <= saida_defuzzy_in;
                else if (estourou) saida <= '0;
            end
        end
    end

`ifdef DEFUZZY_TIMEOUT_EN
    localparam logic [7:0] LIMITE = 8'(TIMEOUT_CICLOS - 1);

    logic [7:0] cnt_espera;
    logic       erro_r;

    // Done has priority: the abort only fires on a cycle where done is low.
    assign estourou     = (estado == ESPERA) && !defuzzy_done && (cnt_espera == LIMITE);
    assign erro_timeout = erro_r;

    always_ff @(posedge clk_0 or posedge Srst) begin
        if (Srst) begin
            cnt_espera <= '0;
            erro_r     <= 1'b0;
        end else begin
            if (estado == DISPARO)     cnt_espera <= '0;
            else if (estado == ESPERA) cnt_espera <= cnt_espera + 8'd1;
            if (estado == ESPERA) begin
                if (defuzzy_done)  erro_r <= 1'b0;
                else if (estourou) erro_r <= 1'b1;
            end
        end
    end
`else
    assign estourou     = 1'b0;
    assign erro_timeout = 1'b0;
`endif

endmodule
